// File: rtl/fractal_sync_wake_tx_pkg.sv
// Shared types for the fractal sync wake-response path.
// Build option: FRACTAL_SYNC_WAKE_CNT_EN enables the event counters.
package fractal_sync_wake_tx_pkg;

  typedef enum logic [1:0] {
    SD_NONE = 2'b00,
    SD_EN   = 2'b01,
    SD_WS   = 2'b10,
    SD_BOTH = 2'b11
  } sd_e;

  typedef enum logic [1:0] {
    HV_NODE = 2'b00,
    RT_NODE = 2'b01
  } node_e;

  localparam int unsigned WAKE_CNT_WIDTH = 32;

  // A response needs a destination; a root only releases level 0.
  function automatic logic resp_legal(
    input node_e node,
    input sd_e   sd,
    input logic  lvl_zero
  );
    return (sd != SD_NONE) &&
           ((node != RT_NODE) || lvl_zero);
  endfunction

endpackage

// File: rtl/fractal_sync_wake_tx_if.sv
// Wake-response bus: one upstream input, EN and WS child outputs.
// Build option: FRACTAL_SYNC_WAKE_CNT_EN (counters are plain ports).
interface fractal_sync_wake_tx_if
  import fractal_sync_wake_tx_pkg::*;
#(
  parameter int unsigned LVL_WIDTH = 2,
  parameter int unsigned ID_WIDTH  = 2
) ();

  logic                 resp_valid_i;
  logic                 resp_ready_o;
  logic [LVL_WIDTH-1:0] resp_level_i;
  logic [ID_WIDTH-1:0]  resp_id_i;
  logic                 resp_err_i;
  sd_e                  resp_sd_i;

  logic                 en_valid_o;
  logic                 en_ready_i;
  logic [LVL_WIDTH-1:0] en_level_o;
  logic [ID_WIDTH-1:0]  en_id_o;
  logic                 en_err_o;

  logic                 ws_valid_o;
  logic                 ws_ready_i;
  logic [LVL_WIDTH-1:0] ws_level_o;
  logic [ID_WIDTH-1:0]  ws_id_o;
  logic                 ws_err_o;

  modport slave (
    input  resp_valid_i, resp_level_i,
    input  resp_id_i, resp_err_i, resp_sd_i,
    output resp_ready_o,
    output en_valid_o, en_level_o,
    output en_id_o, en_err_o,
    input  en_ready_i,
    output ws_valid_o, ws_level_o,
    output ws_id_o, ws_err_o,
    input  ws_ready_i
  );

  modport master (
    output resp_valid_i, resp_level_i,
    output resp_id_i, resp_err_i, resp_sd_i,
    input  resp_ready_o,
    input  en_valid_o, en_level_o,
    input  en_id_o, en_err_o,
    output en_ready_i,
    input  ws_valid_o, ws_level_o,
    input  ws_id_o, ws_err_o,
    output ws_ready_i
  );

endinterface

// File: rtl/fractal_sync_wake_tx_fifo.sv
// Generic response buffer with occupancy counter.
// Build option: FRACTAL_SYNC_WAKE_CNT_EN (not used here).
module fractal_sync_wake_tx_fifo
  import fractal_sync_wake_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ?
           '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/fractal_sync_wake_tx.sv
// Wake-response transmitter: buffers releases and forks them to EN/WS.
// Build option: FRACTAL_SYNC_WAKE_CNT_EN adds saturating event counters.
module fractal_sync_wake_tx
  import fractal_sync_wake_tx_pkg::*;
#(
  parameter int unsigned LVL_WIDTH  = 2,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter node_e       NODE_TYPE  = HV_NODE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fractal_sync_wake_tx_if.slave bus,
  output logic                  drop_o
`ifdef FRACTAL_SYNC_WAKE_CNT_EN
  ,
  output logic [WAKE_CNT_WIDTH-1:0] en_cnt_o,
  output logic [WAKE_CNT_WIDTH-1:0] ws_cnt_o,
  output logic [WAKE_CNT_WIDTH-1:0] drop_cnt_o
`endif
);

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least 1");
  end

  typedef struct packed {
    logic [LVL_WIDTH-1:0] level;
    logic [ID_WIDTH-1:0]  id;
    logic                 err;
    sd_e                  sd;
  } wake_resp_t;

  wake_resp_t in_d;
  wake_resp_t fifo_q;
  wake_resp_t head;
  logic       full;
  logic       empty;
  logic       ready;
  logic       accept;
  logic       legal;
  logic       enq;
  logic       pop;
  logic       live_q;
  logic       sent_en;
  logic       sent_ws;
  logic       drop_q;
  logic       en_valid;
  logic       ws_valid;
  logic       en_hs;
  logic       ws_hs;
  logic       en_done;
  logic       ws_done;
  logic [1:0] head_sd;

  assign in_d = '{
    level: bus.resp_level_i,
    id:    bus.resp_id_i,
    err:   bus.resp_err_i,
    sd:    bus.resp_sd_i
  };

  assign legal = resp_legal(
    NODE_TYPE, bus.resp_sd_i,
    bus.resp_level_i == '0
  );

  // live_q keeps ready low until the first cycle out of reset.
  assign ready  = live_q & ~full;
  assign accept = bus.resp_valid_i & ready;
  assign enq    = accept & legal;

  fractal_sync_wake_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wake_resp_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (enq),
    .data_i  (in_d),
    .pop_i   (pop),
    .data_o  (fifo_q),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head    = empty ? '0 : fifo_q;
  assign head_sd = head.sd;

  assign en_valid = ~empty & head_sd[0] & ~sent_en;
  assign ws_valid = ~empty & head_sd[1] & ~sent_ws;
  assign en_hs    = en_valid & bus.en_ready_i;
  assign ws_hs    = ws_valid & bus.ws_ready_i;
  assign en_done  = ~head_sd[0] | sent_en | en_hs;
  assign ws_done  = ~head_sd[1] | sent_ws | ws_hs;
  assign pop      = ~empty & en_done & ws_done;

  assign bus.resp_ready_o = ready;
  assign bus.en_valid_o   = en_valid;
  assign bus.en_level_o   = head.level;
  assign bus.en_id_o      = head.id;
  assign bus.en_err_o     = head.err;
  assign bus.ws_valid_o   = ws_valid;
  assign bus.ws_level_o   = head.level;
  assign bus.ws_id_o      = head.id;
  assign bus.ws_err_o     = head.err;
  assign drop_o           = drop_q;

  // Per-port sent flags, drop pulse and the out-of-reset marker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q  <= 1'b0;
      sent_en <= 1'b0;
      sent_ws <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      drop_q <= accept & ~legal;
      if (pop) begin
        sent_en <= 1'b0;
        sent_ws <= 1'b0;
      end else begin
        sent_en <= sent_en | en_hs;
        sent_ws <= sent_ws | ws_hs;
      end
    end
  end

`ifdef FRACTAL_SYNC_WAKE_CNT_EN
  localparam logic [WAKE_CNT_WIDTH-1:0] CNT_ONE =
    WAKE_CNT_WIDTH'(1);

  // Saturating counters of handshakes and discarded entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_cnt_o   <= '0;
      ws_cnt_o   <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (en_hs && en_cnt_o != '1)
        en_cnt_o <= en_cnt_o + CNT_ONE;
      if (ws_hs && ws_cnt_o != '1)
        ws_cnt_o <= ws_cnt_o + CNT_ONE;
      if (accept && !legal && drop_cnt_o != '1)
        drop_cnt_o <= drop_cnt_o + CNT_ONE;
    end
  end
`endif

endmodule
